// File: rtl/tblink_rpc_rvarb.sv
`default_nettype none
// ============================================================================
// Module  : tblink_rpc_rvarb
// Brief   : Message-aware round-robin arbiter over 8-bit ready/valid streams.
//           Grant is held for a full tblink RPC message (DST, SIZE, SIZE+1 bytes).
//           Optional TBLINK_RPC_RVARB_STATS_EN adds msg_cnt and gnt_o outputs.
// Revision: 1.0 - initial release
// ============================================================================
module tblink_rpc_rvarb #(
  parameter int N_PORTS = 4,
  parameter int DAT_W   = 8
) (
  input  logic                     uclock,
  input  logic                     reset_n,
  input  logic [N_PORTS*DAT_W-1:0] i_dat,
  input  logic [N_PORTS-1:0]       i_valid,
  output logic [N_PORTS-1:0]       i_ready,
  output logic [DAT_W-1:0]         o_dat,
  output logic                     o_valid,
  input  logic                     o_ready
`ifdef TBLINK_RPC_RVARB_STATS_EN
  ,
  output logic [31:0]              msg_cnt,
  output logic [2:0]               gnt_o
`endif
);

  localparam int c_IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_SIZE = 2'd2,
    ST_BODY = 2'd3
  } state_t;

  state_t             r_st, w_st_nxt;
  logic [c_IDX_W-1:0] r_gnt, w_gnt_nxt;
  logic [c_IDX_W-1:0] r_ptr, w_ptr_nxt;
  logic [c_IDX_W-1:0] w_pick, w_gnt_inc;
  logic [7:0]         r_cnt, w_cnt_nxt;
  logic [DAT_W-1:0]   w_sel_dat;
  logic               w_sel_valid;
  logic               w_xfer;

  // Scan a doubled index range so wrap-around needs no modulo on the pointer;
  // iterating downward leaves the lowest qualifying index as the winner.
  always_comb begin
    w_pick = r_ptr;
    for (int i = 2*N_PORTS-1; i >= 0; i--) begin
      if (i >= int'(r_ptr) && i_valid[i % N_PORTS]) begin
        w_pick = c_IDX_W'(i % N_PORTS);
      end
    end
  end

  always_comb begin
    w_sel_dat   = '0;
    w_sel_valid = 1'b0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (r_gnt == c_IDX_W'(k)) begin
        w_sel_dat   = i_dat[k*DAT_W +: DAT_W];
        w_sel_valid = i_valid[k];
      end
    end
  end

  assign w_gnt_inc = (r_gnt == c_IDX_W'(N_PORTS-1)) ? '0 : r_gnt + 1'b1;

  always_ff @(posedge uclock or negedge reset_n) begin
    if (!reset_n) begin
      r_st  <= ST_IDLE;
      r_gnt <= '0;
      r_ptr <= '0;
      r_cnt <= '0;
    end else begin
      r_st  <= w_st_nxt;
      r_gnt <= w_gnt_nxt;
      r_ptr <= w_ptr_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_st_nxt  = r_st;
    w_gnt_nxt = r_gnt;
    w_ptr_nxt = r_ptr;
    w_cnt_nxt = r_cnt;
    o_dat     = '0;
    o_valid   = 1'b0;
    i_ready   = '0;
    w_xfer    = 1'b0;

    // i_ready depends only on grant state and o_ready, never on i_valid.
    if (r_st != ST_IDLE) begin
      o_dat   = w_sel_dat;
      o_valid = w_sel_valid;
      for (int k = 0; k < N_PORTS; k++) begin
        i_ready[k] = o_ready & (r_gnt == c_IDX_W'(k));
      end
      w_xfer = w_sel_valid & o_ready;
    end

    case (r_st)
      ST_IDLE: begin
        if (|i_valid) begin
          w_gnt_nxt = w_pick;
          w_st_nxt  = ST_HDR;
        end
      end
      ST_HDR: begin
        if (w_xfer) w_st_nxt = ST_SIZE;
      end
      ST_SIZE: begin
        if (w_xfer) begin
          w_cnt_nxt = w_sel_dat[7:0];
          w_st_nxt  = ST_BODY;
        end
      end
      ST_BODY: begin
        if (w_xfer) begin
          if (r_cnt == 8'd0) begin
            w_st_nxt  = ST_IDLE;
            w_ptr_nxt = w_gnt_inc;
          end else begin
            w_cnt_nxt = r_cnt - 8'd1;
          end
        end
      end
      default: w_st_nxt = ST_IDLE;
    endcase
  end

`ifdef TBLINK_RPC_RVARB_STATS_EN
  logic [31:0] r_msg_cnt;

  always_ff @(posedge uclock or negedge reset_n) begin
    if (!reset_n) begin
      r_msg_cnt <= '0;
    end else if (w_xfer && r_st == ST_BODY && r_cnt == 8'd0) begin
      r_msg_cnt <= r_msg_cnt + 32'd1;
    end
  end

  assign msg_cnt = r_msg_cnt;
  assign gnt_o   = (r_st != ST_IDLE) ? r_gnt : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tblink_rpc_rvarb.sv
`default_nettype none
// ============================================================================
// Module  : tb_tblink_rpc_rvarb
// Brief   : Self-checking bench for tblink_rpc_rvarb against a message-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tblink_rpc_rvarb;
  localparam int N = 4;

  logic           uclock  = 1'b0;
  logic           reset_n = 1'b0;
  logic [N*8-1:0] i_dat   = '0;
  logic [N-1:0]   i_valid = '0;
  logic [N-1:0]   i_ready;
  logic [7:0]     o_dat;
  logic           o_valid;
  logic           o_ready = 1'b0;
`ifdef TBLINK_RPC_RVARB_STATS_EN
  logic [31:0]    msg_cnt;
  logic [2:0]     gnt_o;
`endif

  tblink_rpc_rvarb #(.N_PORTS(N), .DAT_W(8)) dut (
    .uclock  (uclock),
    .reset_n (reset_n),
    .i_dat   (i_dat),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .o_dat   (o_dat),
    .o_valid (o_valid),
`ifdef TBLINK_RPC_RVARB_STATS_EN
    .msg_cnt (msg_cnt),
    .gnt_o   (gnt_o),
`endif
    .o_ready (o_ready)
  );

  always #5 uclock = ~uclock;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  logic [7:0] q [N][$];
  logic [N-1:0] hold = '0;
  int rdy_mode  = 0;
  bit rnd_valid = 1'b0;
  bit tog       = 1'b0;

  // Message-level model: owner of the link, bytes moved and message length.
  bit          m_busy  = 1'b0;
  int          m_owner = 0;
  int          m_next  = 0;
  int          m_pos   = 0;
  int          m_len   = 0;
  int unsigned n_msgs  = 0;

  typedef struct { int port; logic [7:0] b; int c; } xfer_t;
  xfer_t xlog[$];
  int    glog[$];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic bit pending();
    for (int k = 0; k < N; k++) if (q[k].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push_msg(input int p, input logic [7:0] dst, input logic [7:0] size,
                          input logic [7:0] first, input logic [7:0] stp);
    q[p].push_back(dst);
    q[p].push_back(size);
    for (int i = 0; i <= int'(size); i++) q[p].push_back(first + 8'(i) * stp);
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      i_valid[k] = (q[k].size() > 0) && !hold[k] && (!rnd_valid || $urandom_range(0, 3) != 0);
      i_dat[k*8 +: 8] = (q[k].size() > 0) ? q[k][0] : 8'($urandom);
    end
    case (rdy_mode)
      0:       o_ready = 1'b1;
      1:       o_ready = ($urandom_range(0, 2) != 0);
      default: begin tog = ~tog; o_ready = tog; end
    endcase
  endtask

  task automatic model_step();
    logic         ev;
    logic [7:0]   ed;
    logic [N-1:0] er;
    ev = 1'b0; ed = 8'h00; er = '0;
    if (m_busy) begin
      ev = i_valid[m_owner];
      ed = i_dat[m_owner*8 +: 8];
      er[m_owner] = o_ready;
    end
    chk("o_valid", o_valid, ev);
    chk("i_ready", i_ready, er);
    chk("o_dat", o_dat, ed);
`ifdef TBLINK_RPC_RVARB_STATS_EN
    chk("gnt_o", gnt_o, m_busy ? m_owner : 0);
    chk("msg_cnt", msg_cnt, n_msgs);
`endif
    if (m_busy) begin
      if (ev && o_ready) begin
        xlog.push_back('{m_owner, ed, cyc});
        void'(q[m_owner].pop_front());
        m_pos++;
        if (m_pos == 2) m_len = int'(ed) + 3;
        if (m_pos == m_len) begin
          m_busy = 1'b0;
          m_next = (m_owner + 1) % N;
          n_msgs++;
        end
      end
    end else if (i_valid != '0) begin
      for (int i = N-1; i >= 0; i--) if (i_valid[(m_next + i) % N]) m_owner = (m_next + i) % N;
      m_busy = 1'b1;
      m_pos  = 0;
      m_len  = 1 << 30;
      glog.push_back(m_owner);
    end
  endtask

  task automatic step();
    @(posedge uclock); #1;
    drive();
    @(negedge uclock);
    cyc++;
    model_step();
  endtask

  task automatic run_idle(input string name, input int budget);
    int n = 0;
    while ((m_busy || pending()) && n < budget) begin
      step();
      n++;
    end
    chk({name, "_drained"}, (m_busy || pending()) ? 0 : 1, 1);
  endtask

  task automatic step_until_xfers(input int cnt, input int budget);
    int n = 0;
    while (xlog.size() < cnt && n < budget) begin
      step();
      n++;
    end
    chk("xfer_wait", (xlog.size() >= cnt) ? 1 : 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_g[6] = '{0, 2, 3, 0, 2, 3};
    int start;
    int vcount;
    int nbytes;
    logic [7:0] sz;

    // Reset state
    repeat (3) step();
    chk("rst_o_valid", o_valid, 0);
    chk("rst_i_ready", i_ready, 0);
    chk("rst_o_dat", o_dat, 0);
    reset_n = 1'b1;
    step();

    // Contention: ports 0,2,3 each stream two SIZE=0 messages
    xlog.delete(); glog.delete();
    for (int r = 0; r < 2; r++) begin
      push_msg(0, 8'h10, 8'h00, 8'(8'h40 + r), 8'h01);
      push_msg(2, 8'h12, 8'h00, 8'(8'h60 + r), 8'h01);
      push_msg(3, 8'h13, 8'h00, 8'(8'h70 + r), 8'h01);
    end
    run_idle("contention", 200);
    chk("contention_msgs", glog.size(), 6);
    chk("contention_bytes", xlog.size(), 18);
    for (int i = 0; i < 6; i++) chk("contention_grant", glog[i], exp_g[i]);
    for (int i = 0; i < 18; i++) chk("contention_nointerleave", xlog[i].port, exp_g[i/3]);

    // Single message on port 1: one IDLE cycle then four consecutive bytes
    xlog.delete(); glog.delete();
    start = cyc;
    push_msg(1, 8'h00, 8'h01, 8'hAA, 8'h11);
    run_idle("single", 50);
    chk("single_len", xlog.size(), 4);
    chk("single_b0", xlog[0].b, 8'h00);
    chk("single_b1", xlog[1].b, 8'h01);
    chk("single_b2", xlog[2].b, 8'hAA);
    chk("single_b3", xlog[3].b, 8'hBB);
    for (int i = 0; i < 4; i++) begin
      chk("single_port", xlog[i].port, 1);
      chk("single_cycle", xlog[i].c, start + 2 + i);
    end

    // Backpressure: o_ready toggles 1010 through a SIZE=3 message on port 0
    xlog.delete();
    rdy_mode = 2; tog = 1'b0;
    push_msg(0, 8'h05, 8'h03, 8'h11, 8'h11);
    run_idle("backpressure", 100);
    rdy_mode = 0;
    chk("bp_len", xlog.size(), 6);
    chk("bp_b1", xlog[1].b, 8'h03);
    chk("bp_b5", xlog[5].b, 8'h44);
    for (int i = 1; i < 6; i++) chk("bp_spacing", xlog[i].c - xlog[i-1].c, 2);

    // Source stall: port 2 drops valid after DST; port 1 requests meanwhile
    xlog.delete(); glog.delete();
    push_msg(2, 8'h07, 8'h01, 8'hC1, 8'h01);
    step_until_xfers(1, 20);
    push_msg(1, 8'h08, 8'h00, 8'hD1, 8'h01);
    hold[2] = 1'b1;
    vcount = 0;
    repeat (5) begin
      step();
      if (o_valid) vcount++;
    end
    chk("stall_valid_cycles", vcount, 0);
    chk("stall_xfers", xlog.size(), 1);
    hold = '0;
    run_idle("stall", 100);
    chk("stall_grant0", glog[0], 2);
    chk("stall_grant1", glog[1], 1);
    chk("stall_len", xlog.size(), 7);
    chk("stall_p2_last", xlog[3].port, 2);
    chk("stall_p1_first", xlog[4].port, 1);

    // Maximum length: SIZE=FF on port 3 gives 258 transfers
    xlog.delete(); glog.delete();
    push_msg(3, 8'h09, 8'hFF, 8'h00, 8'h01);
    run_idle("maxlen", 1000);
    chk("maxlen_len", xlog.size(), 258);
    chk("maxlen_size", xlog[1].b, 8'hFF);
    chk("maxlen_last", xlog[257].b, 8'hFF);
    step();
    chk("maxlen_idle", o_valid, 0);
    glog.delete();
    push_msg(3, 8'h0A, 8'h00, 8'hE3, 8'h01);
    push_msg(0, 8'h0B, 8'h00, 8'hE0, 8'h01);
    run_idle("maxlen_ptr", 50);
    chk("maxlen_ptr_g0", glog[0], 0);
    chk("maxlen_ptr_g1", glog[1], 3);

    // Asynchronous reset in BODY, then a normal message after release
    xlog.delete();
    push_msg(0, 8'h0C, 8'h0A, 8'h20, 8'h01);
    step_until_xfers(5, 30);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_o_valid", o_valid, 0);
    chk("arst_i_ready", i_ready, 0);
    for (int k = 0; k < N; k++) q[k].delete();
    m_busy = 1'b0; m_next = 0; n_msgs = 0;
    repeat (2) step();
    reset_n = 1'b1;
    xlog.delete(); glog.delete();
    push_msg(2, 8'h0D, 8'h01, 8'hF1, 8'h01);
    run_idle("arst_after", 50);
    chk("arst_grant", glog[0], 2);
    chk("arst_len", xlog.size(), 4);
    chk("arst_b3", xlog[3].b, 8'hF2);

    // Six more messages: seven completed since reset
    push_msg(0, 8'h01, 8'h00, 8'h01, 8'h01);
    push_msg(1, 8'h02, 8'h01, 8'h02, 8'h01);
    push_msg(2, 8'h03, 8'h02, 8'h03, 8'h01);
    push_msg(3, 8'h04, 8'h00, 8'h04, 8'h01);
    push_msg(0, 8'h05, 8'h01, 8'h05, 8'h01);
    push_msg(1, 8'h06, 8'h00, 8'h06, 8'h01);
    run_idle("seven", 200);
    chk("seven_msgs", glog.size(), 7);
`ifdef TBLINK_RPC_RVARB_STATS_EN
    step();
    chk("msg_cnt_7", msg_cnt, 7);
`endif

    // Randomized traffic with random valid gaps and backpressure
    xlog.delete();
    rdy_mode = 1; rnd_valid = 1'b1;
    nbytes = 0;
    for (int m = 0; m < 200; m++) begin
      sz = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(10, 40)) : 8'($urandom_range(0, 5));
      push_msg($urandom_range(0, N-1), 8'($urandom), sz, 8'($urandom), 8'($urandom_range(1, 7)));
      nbytes += int'(sz) + 3;
    end
    run_idle("random", 40000);
    chk("random_bytes", xlog.size(), nbytes);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
